// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } pipe_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Bit positions in stage_valid
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational register-compare logic: load-use and RAW stall detection plus
// EX-stage forwarding selects.
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  id_valid,
    input  logic                  ex_valid,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] ex_src_a,
    input  logic [REG_ADDR_W-1:0] ex_src_b,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_wr,
    input  logic                  ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  wb_wr,
    output logic                  load_use,
    output logic                  raw_stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    logic ex_live, mem_live, wb_live;
    logic id_hit_ex, id_hit_mem;

    // A producer only counts when its stage holds a real instruction that writes.
    assign ex_live  = ex_valid  & ex_wr;
    assign mem_live = mem_valid & mem_wr;
    assign wb_live  = wb_valid  & wb_wr;

    assign id_hit_ex  = (id_use_a & (id_src_a == ex_dst))  | (id_use_b & (id_src_b == ex_dst));
    assign id_hit_mem = (id_use_a & (id_src_a == mem_dst)) | (id_use_b & (id_src_b == mem_dst));

    assign load_use  = id_valid & ex_live & ex_mem_rd & id_hit_ex;
    // Write-through regfile: a MEM/WB producer is never a hazard.
    assign raw_stall = !FWD_EN & id_valid & ((ex_live & id_hit_ex) | (mem_live & id_hit_mem));

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (mem_live && (ex_src_a == mem_dst))     fwd_a = FWD_EXMEM;
            else if (wb_live && (ex_src_a == wb_dst))  fwd_a = FWD_MEMWB;
            if (mem_live && (ex_src_b == mem_dst))     fwd_b = FWD_EXMEM;
            else if (wb_live && (ex_src_b == wb_dst))  fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: run/drain/halt FSM, per-register enables and flushes,
// stage valid tracking and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 32,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] ex_src_a,
    input  logic [REG_ADDR_W-1:0] ex_src_b,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_wr,
    input  logic                  ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  wb_wr,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [3:0]            stage_valid,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t st, st_nxt;
    logic [3:0]  vld;
    logic        load_use, raw_stall;
    logic        active, halt_go, br_go, drain_ctl, stall_go;

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_hzd (
        .id_valid (vld[STG_IFID]),
        .ex_valid (vld[STG_IDEX]),
        .mem_valid(vld[STG_EXMEM]),
        .wb_valid (vld[STG_MEMWB]),
        .id_src_a (id_src_a),
        .id_src_b (id_src_b),
        .id_use_a (id_use_a),
        .id_use_b (id_use_b),
        .ex_src_a (ex_src_a),
        .ex_src_b (ex_src_b),
        .ex_dst   (ex_dst),
        .ex_wr    (ex_wr),
        .ex_mem_rd(ex_mem_rd),
        .mem_dst  (mem_dst),
        .mem_wr   (mem_wr),
        .wb_dst   (wb_dst),
        .wb_wr    (wb_wr),
        .load_use (load_use),
        .raw_stall(raw_stall),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b)
    );

    // Accepting HLT already applies drain controls, so the HLT in IF/ID turns
    // into a bubble and the held PC points past it.
    assign active    = (st == ST_RUN) || (st == ST_DRAIN);
    assign halt_go   = (st == ST_RUN) && halt_req && !branch_taken;
    assign br_go     = (st == ST_RUN) && !mem_busy && branch_taken;
    assign drain_ctl = !mem_busy && ((st == ST_DRAIN) || halt_go);
    assign stall_go  = (st == ST_RUN) && !mem_busy && !branch_taken && !halt_go
                       && (load_use || raw_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt     = st;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        case (st)
            ST_IDLE, ST_HALTED: if (start) st_nxt = ST_RUN;
            ST_RUN:             if (halt_go) st_nxt = ST_DRAIN;
            ST_DRAIN:           if (vld[3:1] == 3'b000 && !mem_busy) st_nxt = ST_HALTED;
            default:            st_nxt = ST_IDLE;
        endcase

        if (active && !mem_busy) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            if (br_go) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (drain_ctl) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall_go) begin
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 4'b0000;
        end else if (active && !mem_busy) begin
            vld[STG_MEMWB] <= vld[STG_EXMEM];
            vld[STG_EXMEM] <= vld[STG_IDEX];
            vld[STG_IDEX]  <= (br_go || stall_go || drain_ctl) ? 1'b0 : vld[STG_IFID];
            vld[STG_IFID]  <= (br_go || drain_ctl) ? 1'b0 : (stall_go ? vld[STG_IFID] : 1'b1);
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (active && !(&cycle_cnt))
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (active && (mem_busy || stall_go) && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (vld[STG_MEMWB] && !mem_busy && !(&retire_cnt))
                retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

    assign stage_valid = vld;
    assign state       = st;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage 16-bit core (IF, ID, EX, MEM, WB). It replaces the free-running, always-enabled pipeline-register update with per-register enables and flushes. It also adds a run/drain/halt state machine, load-use and RAW hazard stalls, EX-stage operand forwarding selects, branch flush, multi-cycle memory freeze and saturating performance counters. It sits beside the datapath top: it consumes register addresses and control bits from the pipeline registers, and drives the datapath's enable, flush and forwarding-mux inputs.

## Interface
- REG_ADDR_W, 3, register-address width
- CNT_W, 32, width of each performance counter
- FWD_EN, 1, 1 = forwarding enabled; 0 = RAW hazards resolved by stalling, fwd selects tied to 00
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave IDLE/HALTED, enter RUN
- halt_req  in  1  HLT decoded in ID (IF/ID holds HLT)
- id_src_a, id_src_b  in  REG_ADDR_W  ID-stage source registers
- id_use_a, id_use_b  in  1  ID instruction reads src a / src b
- ex_src_a, ex_src_b  in  REG_ADDR_W  sources of the instruction in ID/EX
- ex_dst  in  REG_ADDR_W  destination in ID/EX
- ex_wr  in  1  ID/EX writes a register
- ex_mem_rd  in  1  ID/EX is a load
- mem_dst, mem_wr  in  REG_ADDR_W, 1  EX/MEM destination / write flag
- wb_dst, wb_wr  in  REG_ADDR_W, 1  MEM/WB destination / write flag
- branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush  out  1 each  synchronous clear-to-bubble
- fwd_a, fwd_b  out  2 each  00 regfile/ID-EX value, 01 EX/MEM result, 10 MEM/WB result
- stage_valid  out  4  valid bits: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
- state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 HALTED
- cycle_cnt, stall_cnt, retire_cnt  out  CNT_W each  performance counters

## Operation
- **Reset values.** state=IDLE, stage_valid=0, counters=0, all enables/flushes=0, fwd=00.
- **IDLE.** All enables 0. start → RUN.
- **RUN → DRAIN.** On halt_req, unless branch_taken is also asserted in that cycle.
- **DRAIN.**
  - pc_en=0; IF/ID loads a bubble; the HLT itself becomes a bubble.
  - Downstream stages continue.
  - When stage_valid[3:1]==0 and !mem_busy, go to HALTED.
- **HALTED.** All enables 0. start → RUN, resuming from the held PC.
- **Hazard gating.** Every hazard compare is qualified by the relevant stage_valid bit and its wr flag.
- **Load-use hazard.** ID source (with use bit) == ex_dst, and ex_wr & ex_mem_rd.
- **RAW hazard (FWD_EN=0 only).** ID source == ex_dst (ex_wr), or == mem_dst (mem_wr). The regfile is write-through, so WB is never a hazard.
- **Stall.** pc_en=0, ifid_en=0, idex_flush=1; later stages advance.
- **Control priority, highest first:**
  - mem_busy: all enables 0, no flush, valid bits hold.
  - branch_taken: pc_en=1, ifid_flush=1, idex_flush=1; any stall and halt_req are ignored.
  - Stall (load-use or RAW).
  - Otherwise all enables 1 (in RUN).
- **Forwarding (FWD_EN=1, combinational).** For each EX source:
  - 01 if it matches a valid mem_dst with mem_wr;
  - else 10 if it matches a valid wb_dst with wb_wr;
  - else 00.
  - EX/MEM wins over MEM/WB.
- **Valid-bit update** (when not frozen):
  - v3←v2; v2←v1;
  - v1←0 on flush/stall/DRAIN, else v0;
  - v0←0 on branch/DRAIN; hold on stall; 1 in RUN otherwise.
- **Counters** (all saturate at all-ones, never wrap):
  - cycle_cnt increments in RUN or DRAIN.
  - stall_cnt increments on cycles with mem_busy, load-use or RAW stall (one count per cycle).
  - retire_cnt increments when v3 & !mem_busy.

## Timing
- Enables, flushes and fwd are combinational from the current inputs and state, and are valid in the same cycle.
- state, stage_valid and the counters update on posedge clk.
- Load-use stall lasts exactly 1 cycle. A RAW stall with FWD_EN=0 lasts up to 2 cycles.
- Branch penalty: 2 bubbles.
- rst mid-operation clears everything immediately (asynchronously); an in-flight DRAIN is abandoned.
- start while in RUN or DRAIN is ignored.
- mem_busy held N cycles freezes the pipeline for exactly N cycles and adds N to stall_cnt.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/HALTED);
  - fwd select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - stage-index constants.
- One sub-module: hazard_fwd_unit, the purely combinational compare logic producing load_use, raw_stall, fwd_a and fwd_b.
- The FSM, valid tracking and counters live in the top module.

## Test plan
- Reset then start, 4 independent ALU instructions: stage_valid fills 0001→0011→0111→1111; retire_cnt=4 after 4 further cycles; stall_cnt=0.
- Load into r2 in ID/EX while ID reads r2: one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle, consumer in EX gets fwd_a=10; stall_cnt=1.
- ADD r3 in EX/MEM and ADD r3 in MEM/WB, EX reads r3 (FWD_EN=1): fwd_a=01. Repeat with FWD_EN=0: two stall cycles, fwd_a=00.
- branch_taken asserted together with a load-use hazard and halt_req: ifid_flush=idex_flush=1, pc_en=1, state stays RUN, v0 and v1 cleared.
- halt_req in RUN: state=DRAIN, pc_en=0; HALTED after 3 cycles. Then start → RUN.
- mem_busy held 3 cycles mid-run: all enables 0, stage_valid frozen, stall_cnt +3. Assert rst during the freeze: all outputs return to reset values immediately.
